full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameter WIDTH, default 1: operand width in bits; legal range 1..64.
REQ-003 Parameter REGISTERED, default 1: 1 = outputs registered on clk; 0 = outputs purely combinational, with clk and rst ignored.
REQ-004 clk  input  1  rising-edge clock for the output registers.
REQ-005 rst  input  1  asynchronous active-high reset of the output registers.
REQ-006 a  input  WIDTH  first addend, unsigned.
REQ-007 b  input  WIDTH  second addend, unsigned.
REQ-008 c  input  1  carry-in.
REQ-009 sum  output  WIDTH  low WIDTH bits of a+b+c.
REQ-010 carry  output  1  carry-out, bit WIDTH of a+b+c.

Function
REQ-011 The block SHALL compute {carry,sum} = a + b + c as an unsigned (WIDTH+1)-bit result, with no truncation or saturation.
REQ-012 For WIDTH=1, sum SHALL equal a XOR b XOR c, and carry SHALL equal (a AND b) OR (a AND c) OR (b AND c).
REQ-013 For WIDTH>1, the result SHALL equal a ripple chain of WIDTH 1-bit full-adder cells: c feeds bit 0, and each cell's carry feeds the next bit; the final cell's carry drives carry.
REQ-014 REGISTERED=1: sum and carry SHALL update on each rising clk edge with the result of the a/b/c values sampled at that edge; latency is 1 cycle, throughput is 1 result per cycle, and outputs hold between edges.
REQ-015 REGISTERED=0: sum and carry SHALL follow a/b/c combinationally within the same delta/timestep, with no storage.
REQ-016 Wrap-around: all-ones a plus all-ones b plus c=1 SHALL give sum = all-ones and carry = 1; all-ones a plus b=0 plus c=1 SHALL give sum = 0 and carry = 1.
REQ-017 The block SHALL contain no X-propagation sources other than X/Z on its inputs; it SHALL contain no latches.
REQ-018 There SHALL be no handshake; every clock edge is a valid sample.

Reset
REQ-019 REGISTERED=1: asserting rst SHALL force sum=0 and carry=0 immediately, independent of clk.
REQ-020 While rst is high, the outputs SHALL stay 0 regardless of the inputs or clock edges.
REQ-021 After rst deasserts, the first rising clk edge SHALL load the current a+b+c.
REQ-022 If rst is asserted mid-operation, any pending result SHALL be discarded and SHALL NOT appear after release.
REQ-023 REGISTERED=0: rst SHALL have no effect.

Verification
REQ-024 WIDTH=1, REGISTERED=0, exhaustive sweep of (a,b,c) from 000 to 111, one step per time unit, SHALL give {carry,sum} = 00,01,01,10,01,10,10,11.
REQ-025 WIDTH=1, REGISTERED=1, the same 8-vector sweep applied one per clk edge SHALL give the identical sequence, delayed by exactly 1 cycle.
REQ-026 REGISTERED=1, a=1, b=1, c=1 loaded, then rst pulsed between clk edges, SHALL drive sum and carry to 0 before the next edge; after release, the first edge SHALL show 1/1.
REQ-027 WIDTH=8, REGISTERED=0, a=0xFF, b=0x01, c=0 SHALL give sum=0x00, carry=1; a=0xFF, b=0xFF, c=1 SHALL give sum=0xFF, carry=1.
REQ-028 WIDTH=8, REGISTERED=1, 1000 random vectors SHALL match a reference model of (a+b+c) with 1-cycle latency, and no X SHALL appear after reset.

Source files
------------

// File: rtl/full_adder.sv
// Unsigned WIDTH-bit ripple-carry adder: {carry,sum} = a + b + c.
// With REGISTERED=1 the result is captured on clk; with REGISTERED=0 the outputs are combinational.
module full_adder #(
   parameter int WIDTH      = 1,
   parameter int REGISTERED = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;

   assign w_carry[0] = c;

   // One full-adder cell per bit; each cell's carry-out ripples into the next bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign w_sum[i]     = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
   end

   if (REGISTERED != 0) begin : g_reg
      logic [WIDTH-1:0] r_sum;
      logic             r_carry;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
         end else begin
            r_sum   <= w_sum;
            r_carry <= w_carry[WIDTH];
         end
      end

      assign sum   = r_sum;
      assign carry = r_carry;
   end else begin : g_comb
      assign sum   = w_sum;
      assign carry = w_carry[WIDTH];
   end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: 1-bit and 8-bit instances, registered and combinational,
// compared against a plain-arithmetic reference model.
module tb_full_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       c8 = 1'b0;

   logic       s1_c, co1_c, s1_r, co1_r;
   logic [7:0] s8_c, s8_r;
   logic       co8_c, co8_r;

   int n_chk = 0;
   int n_err = 0;

   logic [1:0] exp_tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   full_adder #(.WIDTH(1), .REGISTERED(0)) u_w1_comb (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .sum(s1_c), .carry(co1_c));
   full_adder #(.WIDTH(1), .REGISTERED(1)) u_w1_reg (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .sum(s1_r), .carry(co1_r));
   full_adder #(.WIDTH(8), .REGISTERED(0)) u_w8_comb (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .sum(s8_c), .carry(co8_c));
   full_adder #(.WIDTH(8), .REGISTERED(1)) u_w8_reg (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .sum(s8_r), .carry(co8_r));

   always #5 clk = ~clk;

   function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                           input logic ci);
      return {1'b0, x} + {1'b0, y} + {64'd0, ci};
   endfunction

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [8:0] exp8;
      logic [1:0] exp1;

      // Reset: outputs forced low immediately, and held through clock edges with nonzero inputs.
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      a8 = 8'hA5; b8 = 8'h3C; c8 = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("rst_async_w1", {co1_r, s1_r}, 2'b00);
      chk("rst_async_w8", {co8_r, s8_r}, 9'h000);
      @(posedge clk); @(posedge clk); #1;
      chk("rst_hold_w1", {co1_r, s1_r}, 2'b00);
      chk("rst_hold_w8", {co8_r, s8_r}, 9'h000);
      chk("rst_ignored_comb_w1", {co1_c, s1_c}, ref_add(64'(a1), 64'(b1), c1));
      chk("rst_ignored_comb_w8", {co8_c, s8_c}, ref_add(64'(a8), 64'(b8), c8));

      // First edge after release loads the current inputs.
      @(negedge clk) rst = 1'b0;
      exp8 = ref_add(64'(a8), 64'(b8), c8);
      @(posedge clk); #1;
      chk("first_edge_w8", {co8_r, s8_r}, exp8);

      // Exhaustive combinational sweep, one vector per time unit.
      for (int i = 0; i < 8; i++) begin
         {a1, b1, c1} = 3'(i);
         #1;
         chk("sweep_comb_tbl", {co1_c, s1_c}, exp_tbl[i]);
         chk("sweep_comb_ref", {co1_c, s1_c}, ref_add(64'(a1), 64'(b1), c1));
      end

      // Registered sweep: one vector per edge, visible right after that edge, held until the next.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         {a1, b1, c1} = 3'(i);
         #1;
         if (i > 0) chk("sweep_reg_hold", {co1_r, s1_r}, exp_tbl[i-1]);
         @(posedge clk); #1;
         chk("sweep_reg_tbl", {co1_r, s1_r}, exp_tbl[i]);
      end

      // Reset pulse between edges discards the loaded 1/1; first edge after release reloads it.
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      @(posedge clk); #1;
      chk("pulse_loaded", {co1_r, s1_r}, 2'b11);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("pulse_rst_w1", {co1_r, s1_r}, 2'b00);
      #1 rst = 1'b0;
      #1;
      chk("pulse_released_w1", {co1_r, s1_r}, 2'b00);
      @(posedge clk); #1;
      chk("pulse_reload_w1", {co1_r, s1_r}, 2'b11);

      // 8-bit boundary cases.
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
      #1 chk("w8_ff_01_0", {co8_c, s8_c}, 9'h100);
      a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
      #1 chk("w8_ff_ff_1", {co8_c, s8_c}, 9'h1FF);
      a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
      #1 chk("w8_ff_00_1", {co8_c, s8_c}, 9'h100);
      @(posedge clk); #1;
      chk("w8_reg_ff_00_1", {co8_r, s8_r}, 9'h100);

      // Random 8-bit vectors, combinational and registered, plus random 1-bit vectors.
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         c8 = 1'($urandom);
         {a1, b1, c1} = 3'($urandom_range(7));
         exp8 = ref_add(64'(a8), 64'(b8), c8);
         exp1 = 2'(ref_add(64'(a1), 64'(b1), c1));
         #1;
         chk("rand_comb_w8", {co8_c, s8_c}, exp8);
         @(posedge clk); #1;
         chk("rand_reg_w8", {co8_r, s8_r}, exp8);
         chk("rand_reg_w1", {co1_r, s1_r}, exp1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
